// File: rtl/add_sub_pkg.sv
// Shared encodings for the digit-serial add/sub unit: FSM states and op codes.
package add_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_serial_if.sv
// Operand/result handshake bundle for add_sub_serial; the producer/consumer side
// uses master, the add/sub unit uses slave.
interface add_sub_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             add_sub_select;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] z;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, x, y, add_sub_select, out_ready,
      input  in_ready, out_valid, z, carry_out, overflow, zero
   );

   modport slave (
      input  in_valid, x, y, add_sub_select, out_ready,
      output in_ready, out_valid, z, carry_out, overflow, zero
   );
endinterface

// File: rtl/add_sub_digit.sv
// Combinational DIGIT-bit ripple adder slice; the serial unit reuses one
// instance for every digit of an operation.
module add_sub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_cin,
   output logic [DIGIT-1:0] o_sum,
   output logic             o_cout
);

   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock, LSB first.
// Build with ADD_SUB_SATURATE_EN defined to saturate z on signed overflow.
module add_sub_serial
   import add_sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   add_sub_serial_if.slave  s_if
);

   // WIDTH must be a multiple of DIGIT.
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_e                        r_state;
   state_e                        w_next;
   logic [NDIG-1:0][DIGIT-1:0]    r_x;
   logic [NDIG-1:0][DIGIT-1:0]    r_y;
   logic [NDIG-1:0][DIGIT-1:0]    r_z;
   logic [NDIG-1:0][DIGIT-1:0]    w_z_final;
   logic [NDIG-1:0][DIGIT-1:0]    w_z_out;
   logic [CW-1:0]                 r_cnt;
   logic                          r_carry;
   logic                          r_carry_out;
   logic                          r_overflow;
   logic                          r_zero;
   logic [DIGIT-1:0]              w_sum;
   logic                          w_cout;
   logic                          w_accept;
   logic                          w_last;
   logic                          w_ovf;

   assign w_accept = (r_state == ST_IDLE) && s_if.in_valid;
   assign w_last   = (r_state == ST_BUSY) && (r_cnt == CW'(NDIG - 1));

   add_sub_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .i_a    (r_x[r_cnt]),
      .i_b    (r_y[r_cnt]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_z_final        = r_z;
      w_z_final[r_cnt] = w_sum;
   end

   // y is stored pre-inverted for subtract, so its sign bit is already y'.
   assign w_ovf = (r_x[NDIG-1][DIGIT-1] == r_y[NDIG-1][DIGIT-1]) &&
                  (w_z_final[NDIG-1][DIGIT-1] != r_x[NDIG-1][DIGIT-1]);

`ifdef ADD_SUB_SATURATE_EN
   always_comb begin
      w_z_out = w_z_final;
      if (w_ovf) begin
         w_z_out = r_x[NDIG-1][DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign w_z_out = w_z_final;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (s_if.in_valid)  w_next = ST_BUSY;
         ST_BUSY: if (w_last)         w_next = ST_DONE;
         ST_DONE: if (s_if.out_ready) w_next = ST_IDLE;
         default:                     w_next = ST_IDLE;
      endcase
   end

   // NOTE: operand registers are reset too, so an aborted operation leaves no stale state behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_accept) begin
         r_x     <= s_if.x;
         r_y     <= (s_if.add_sub_select == OP_SUB) ? ~s_if.y : s_if.y;
         r_carry <= s_if.add_sub_select;
         r_cnt   <= '0;
      end else if (r_state == ST_BUSY) begin
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_z         <= w_z_out;
            r_carry_out <= w_cout;
            r_overflow  <= w_ovf;
            r_zero      <= (w_z_out == '0);
         end else begin
            r_z[r_cnt] <= w_sum;
         end
      end
   end

   assign s_if.in_ready  = (r_state == ST_IDLE);
   assign s_if.out_valid = (r_state == ST_DONE);
   assign s_if.z         = r_z;
   assign s_if.carry_out = r_carry_out;
   assign s_if.overflow  = r_overflow;
   assign s_if.zero      = r_zero;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial: DIGIT=4 main instance plus a DIGIT=16 instance.
module tb_add_sub_serial;
   import add_sub_pkg::*;

   typedef struct {
      logic [15:0] z;
      logic        cout;
      logic        ov;
      logic        zero;
      int          lat;
   } exp_t;

`ifdef ADD_SUB_SATURATE_EN
   localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
   localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
   localparam bit          SAT         = 1'b1;
`else
   localparam logic [15:0] EXP_POS_OVF = 16'h8000;
   localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
   localparam bit          SAT         = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   add_sub_serial_if #(.WIDTH(16)) bus4 ();
   add_sub_serial_if #(.WIDTH(16)) bus16 ();

   add_sub_serial #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .s_if(bus4));
   add_sub_serial #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .s_if(bus16));

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   function automatic exp_t mk(input logic [15:0] z, input logic c, input logic o, input logic zr);
      exp_t e;
      e.z = z; e.cout = c; e.ov = o; e.zero = zr; e.lat = 4;
      return e;
   endfunction

   // Reference model from full-width arithmetic, used for the randomised ops.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic op);
      exp_t        e;
      logic [15:0] bb;
      logic [16:0] s;
      bb     = op ? ~b : b;
      s      = {1'b0, a} + {1'b0, bb} + {16'd0, op};
      e.z    = s[15:0];
      e.cout = s[16];
      e.ov   = (a[15] == bb[15]) && (s[15] != a[15]);
      if (SAT && e.ov) e.z = a[15] ? 16'h8000 : 16'h7FFF;
      e.zero = (e.z == 16'h0000);
      e.lat  = 4;
      return e;
   endfunction

   task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic op, input exp_t e);
      bit acc;
      int n;
      n = 0;
      bus4.x = a; bus4.y = b; bus4.add_sub_select = op; bus4.in_valid = 1'b1;
      sb.push_back(e);
      do begin
         acc = bus4.in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 50);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: in_ready never seen after %0d cycles", n);
      end
      bus4.in_valid = 1'b0;
   endtask

   task automatic collect(input int hold, input string name);
      exp_t        e;
      int          lat;
      logic [15:0] z0;
      logic [2:0]  f0;
      lat = 0;
      while (!bus4.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (!bus4.out_valid || sb.size() == 0) begin
         errors++;
         $display("FAIL %s_timeout: out_valid=%0b queued=%0d", name, bus4.out_valid, sb.size());
         return;
      end
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, e.lat); end
      checks++;
      if (bus4.z !== e.z) begin errors++; $display("FAIL %s_z: got %h expected %h", name, bus4.z, e.z); end
      checks++;
      if (bus4.carry_out !== e.cout) begin errors++; $display("FAIL %s_carry: got %b expected %b", name, bus4.carry_out, e.cout); end
      checks++;
      if (bus4.overflow !== e.ov) begin errors++; $display("FAIL %s_overflow: got %b expected %b", name, bus4.overflow, e.ov); end
      checks++;
      if (bus4.zero !== e.zero) begin errors++; $display("FAIL %s_zero: got %b expected %b", name, bus4.zero, e.zero); end
      z0 = bus4.z;
      f0 = {bus4.carry_out, bus4.overflow, bus4.zero};
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0 || bus4.z !== z0 ||
             {bus4.carry_out, bus4.overflow, bus4.zero} !== f0) begin
            errors++;
            $display("FAIL %s_hold%0d: valid=%b ready=%b z=%h flags=%b expected valid=1 ready=0 z=%h flags=%b",
                     name, i, bus4.out_valid, bus4.in_ready, bus4.z,
                     {bus4.carry_out, bus4.overflow, bus4.zero}, z0, f0);
         end
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_release: valid=%b ready=%b expected valid=0 ready=1", name, bus4.out_valid, bus4.in_ready);
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.z !== 16'h0000 ||
          bus4.carry_out !== 1'b0 || bus4.overflow !== 1'b0 || bus4.zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: ready=%b valid=%b z=%h c=%b o=%b zr=%b expected 1 0 0000 0 0 0",
                  bus4.in_ready, bus4.out_valid, bus4.z, bus4.carry_out, bus4.overflow, bus4.zero);
      end
      checks++;
      if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.z !== 16'h0000) begin
         errors++;
         $display("FAIL reset_values16: ready=%b valid=%b z=%h expected 1 0 0000",
                  bus16.in_ready, bus16.out_valid, bus16.z);
      end
      // Run to DONE with a nonzero result, then reset between clock edges.
      drive_op(16'hFFFF, 16'h0002, OP_ADD, mk(16'h0001, 1'b1, 1'b0, 1'b0));
      n = 0;
      while (!bus4.out_valid && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (bus4.z !== 16'h0001 || bus4.carry_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre: z=%h c=%b expected 0001 1", bus4.z, bus4.carry_out);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.z !== 16'h0000 || bus4.carry_out !== 1'b0 || bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: valid=%b z=%h c=%b ready=%b expected 0 0000 0 1",
                  bus4.out_valid, bus4.z, bus4.carry_out, bus4.in_ready);
      end
      rst_n = 1'b1;
      sb.delete();
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      drive_op(16'h1234, 16'h0FFF, OP_ADD, mk(16'h2233, 1'b0, 1'b0, 1'b0));
      collect(0, "add");
      drive_op(16'hFFFF, 16'h0001, OP_ADD, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      collect(0, "wrap");
   endtask

   task automatic test_sub();
      drive_op(16'h0009, 16'h0009, OP_SUB, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      collect(0, "sub_eq");
      drive_op(16'h000A, 16'h000F, OP_SUB, mk(16'hFFFB, 1'b0, 1'b0, 1'b0));
      collect(0, "sub_borrow");
   endtask

   task automatic test_overflow();
      drive_op(16'h7FFF, 16'h0001, OP_ADD, mk(EXP_POS_OVF, 1'b0, 1'b1, 1'b0));
      collect(0, "ovf_pos");
      drive_op(16'h8000, 16'h0001, OP_SUB, mk(EXP_NEG_OVF, 1'b1, 1'b1, 1'b0));
      collect(0, "ovf_neg");
   endtask

   task automatic test_back_to_back();
      drive_op(16'h0100, 16'h0200, OP_ADD, mk(16'h0300, 1'b0, 1'b0, 1'b0));
      // Second request waits on the bus while the first result is back-pressured.
      bus4.x = 16'h0001; bus4.y = 16'h0002; bus4.add_sub_select = OP_ADD; bus4.in_valid = 1'b1;
      collect(5, "bp_first");
      drive_op(16'h0001, 16'h0002, OP_ADD, mk(16'h0003, 1'b0, 1'b0, 1'b0));
      collect(0, "bp_second");
   endtask

   task automatic test_abort();
      int seen;
      drive_op(16'h1111, 16'h2222, OP_ADD, mk(16'h3333, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.z !== 16'h0000) begin
         errors++;
         $display("FAIL abort_clear: valid=%b ready=%b z=%h expected 0 1 0000", bus4.out_valid, bus4.in_ready, bus4.z);
      end
      rst_n = 1'b1;
      sb.delete();
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus4.out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL abort_no_result: out_valid seen %0d cycles expected 0", seen); end
      drive_op(16'h0003, 16'h000C, OP_ADD, mk(16'h000F, 1'b0, 1'b0, 1'b0));
      collect(0, "after_abort");
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic        op;
      for (int i = 0; i < 8; i++) begin
         a  = 16'($urandom);
         b  = 16'($urandom);
         op = 1'($urandom_range(0, 1));
         drive_op(a, b, op, model(a, b, op));
         collect(0, "random");
      end
   endtask

   task automatic test_digit16();
      int lat;
      bit acc;
      bus16.x = 16'h1234; bus16.y = 16'h0FFF; bus16.add_sub_select = OP_ADD; bus16.in_valid = 1'b1;
      lat = 0;
      do begin
         acc = bus16.in_ready;
         @(posedge clk); #1;
         lat++;
      end while (!acc && lat < 50);
      bus16.in_valid = 1'b0;
      lat = 0;
      while (!bus16.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL d16_latency: got %0d expected 1", lat); end
      checks++;
      if (bus16.z !== 16'h2233 || bus16.carry_out !== 1'b0 || bus16.overflow !== 1'b0 || bus16.zero !== 1'b0) begin
         errors++;
         $display("FAIL d16_result: z=%h c=%b o=%b zr=%b expected 2233 0 0 0",
                  bus16.z, bus16.carry_out, bus16.overflow, bus16.zero);
      end
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
      checks++;
      if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL d16_release: valid=%b ready=%b expected 0 1", bus16.out_valid, bus16.in_ready);
      end
   endtask

   initial begin
      bus4.in_valid = 1'b0;  bus4.out_ready = 1'b0;  bus4.x = '0;  bus4.y = '0;  bus4.add_sub_select = OP_ADD;
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.x = '0; bus16.y = '0; bus16.add_sub_select = OP_ADD;
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_back_to_back();
      test_abort();
      test_random();
      test_digit16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
